blake2s_block_sched: RTL and testbench

- Sequencer between the byte-stream host interface and the BLAKE2s compression core.
- Accepts one hash job (kk, nn, ll), then pulls key and message bytes with backpressure.
- Presents them to the core as 64-byte blocks indexed 0..63, with block_first/block_last flags and zero padding.
- Stalls between blocks until the core has consumed the block, and signals job completion.

---
 rtl/blake2s_pkg.sv | 20 ++
 rtl/blake2s_block_sched_if.sv | 22 ++
 rtl/blake2s_byte_cnt.sv | 52 +++++
 rtl/blake2s_block_sched.sv | 203 ++++++++++++++++++++
 tb/tb_blake2s_block_sched.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/blake2s_pkg.sv
// rtl/blake2s_pkg.sv - shared state type, block/key/digest limits and cfg check for the BLAKE2s block scheduler
package blake2s_pkg;
  localparam int BLOCK_BYTES = 64;
  localparam int KK_MAX      = 32;
  localparam int NN_MAX      = 32;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_KEY       = 3'd1,
    S_MSG       = 3'd2,
    S_PAD       = 3'd3,
    S_WAIT_CORE = 3'd4,
    S_WAIT_FIN  = 3'd5,
    S_DONE      = 3'd6
  } state_e;

  function automatic logic cfg_ok(input logic [7:0] kk, input logic [7:0] nn);
    return (kk <= 8'(KK_MAX)) && (nn != 8'd0) && (nn <= 8'(NN_MAX));
  endfunction
endpackage

// File: rtl/blake2s_block_sched_if.sv
// rtl/blake2s_block_sched_if.sv - scheduler-to-compression-core block bus (master = scheduler, slave = core)
interface blake2s_block_sched_if #(
  parameter int BLOCK_W = 6
);
  logic               data_v_o;
  logic [7:0]         data_o;
  logic [BLOCK_W-1:0] data_idx_o;
  logic               block_first_o;
  logic               block_last_o;
  logic               core_block_done_i;
  logic               core_finished_i;

  modport master (
    output data_v_o, data_o, data_idx_o, block_first_o, block_last_o,
    input  core_block_done_i, core_finished_i
  );

  modport slave (
    input  data_v_o, data_o, data_idx_o, block_first_o, block_last_o,
    output core_block_done_i, core_finished_i
  );
endinterface

// File: rtl/blake2s_byte_cnt.sv
// rtl/blake2s_byte_cnt.sv - remaining-message counter, in-block byte index and final-block detect
module blake2s_byte_cnt
  import blake2s_pkg::*;
#(
  parameter int BLOCK_W = 6,
  parameter int LL_W    = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic [LL_W-1:0]    ll_i,
  input  logic               dec_i,
  input  logic               step_i,
  input  logic               key_blk_i,
  input  logic               ll_zero_i,
  output logic [BLOCK_W-1:0] idx_o,
  output logic               rem_last_o,
  output logic               final_o
);
  logic [BLOCK_W-1:0] idx_q, idx_d;
  logic [LL_W-1:0]    rem_q, rem_d;
  logic [LL_W-1:0]    lim;

  always_comb begin
    idx_d = idx_q;
    rem_d = rem_q;
    if (load_i) begin
      idx_d = '0;
      rem_d = ll_i;
    end else begin
      if (step_i) idx_d = idx_q + 1'b1;
      if (dec_i)  rem_d = rem_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= '0;
      rem_q <= '0;
    end else begin
      idx_q <= idx_d;
      rem_q <= rem_d;
    end
  end

  // rem + idx is constant across a message block, so "rem fits in what is left of
  // this block" marks the final block from its first byte to its last.
  assign lim        = LL_W'(BLOCK_BYTES) - LL_W'(idx_q);
  assign final_o    = key_blk_i ? ll_zero_i : (rem_q <= lim);
  assign rem_last_o = (rem_q == LL_W'(1));
  assign idx_o      = idx_q;
endmodule

// File: rtl/blake2s_block_sched.sv
// rtl/blake2s_block_sched.sv - BLAKE2s job sequencer: byte stream in, padded 64-byte blocks out to the core
// Optional cycle counter output cycles_o is enabled by defining BLAKE2S_SCHED_PERF_EN.
module blake2s_block_sched
  import blake2s_pkg::*;
#(
  parameter int BLOCK_W = 6,
  parameter int LL_W    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_v_i,
  input  logic [7:0]            kk_i,
  input  logic [7:0]            nn_i,
  input  logic [LL_W-1:0]       ll_i,
  output logic                  cfg_err_o,
  input  logic                  msg_v_i,
  input  logic [7:0]            msg_i,
  output logic                  msg_ready_o,
  output logic [7:0]            kk_o,
  output logic [7:0]            nn_o,
  output logic [LL_W-1:0]       ll_o,
  blake2s_block_sched_if.master core,
  output logic                  busy_o,
  output logic                  done_o
`ifdef BLAKE2S_SCHED_PERF_EN
  ,
  output logic [31:0]           cycles_o
`endif
);
  state_e             state_q, state_d;
  logic [7:0]         kk_q, kk_d, nn_q, nn_d;
  logic [LL_W-1:0]    ll_q, ll_d;
  logic               first_q, first_d;
  logic               key_blk_q, key_blk_d;
  logic               cfg_err_q, cfg_err_d;
  logic               data_v_q, data_v_d;
  logic [7:0]         data_q, data_d;
  logic [BLOCK_W-1:0] data_idx_q, data_idx_d;
  logic               block_first_q, block_first_d;
  logic               block_last_q, block_last_d;

  logic               cfg_good, accept, take, emit, in_pad, idx_last, rem_last, is_final;
  logic [BLOCK_W-1:0] idx;

  assign cfg_good = cfg_ok(kk_i, nn_i);
  assign accept   = (state_q == S_IDLE) && cfg_v_i && cfg_good;
  assign in_pad   = (state_q == S_PAD);
  assign take     = msg_ready_o && msg_v_i;
  assign emit     = take || in_pad;
  assign idx_last = &idx;

  blake2s_byte_cnt #(
    .BLOCK_W (BLOCK_W),
    .LL_W    (LL_W)
  ) u_byte_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (accept),
    .ll_i       (ll_i),
    .dec_i      (take && (state_q == S_MSG)),
    .step_i     (emit),
    .key_blk_i  (key_blk_q),
    .ll_zero_i  (ll_q == '0),
    .idx_o      (idx),
    .rem_last_o (rem_last),
    .final_o    (is_final)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (kk_i != 8'd0)     state_d = S_KEY;
          else if (ll_i != '0)  state_d = S_MSG;
          else                  state_d = S_PAD;
        end
      end
      S_KEY: begin
        if (take && (8'(idx) == kk_q - 8'd1)) state_d = S_PAD;
      end
      S_MSG: begin
        // A byte landing at idx 63 closes the block even if it was also the last byte.
        if (take) begin
          if (idx_last)      state_d = is_final ? S_WAIT_FIN : S_WAIT_CORE;
          else if (rem_last) state_d = S_PAD;
        end
      end
      S_PAD: begin
        if (idx_last) state_d = is_final ? S_WAIT_FIN : S_WAIT_CORE;
      end
      S_WAIT_CORE: begin
        if (core.core_block_done_i) state_d = S_MSG;
      end
      S_WAIT_FIN: begin
        if (core.core_finished_i) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    msg_ready_o = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    case (state_q)
      S_KEY, S_MSG: begin
        msg_ready_o = 1'b1;
        busy_o      = 1'b1;
      end
      S_PAD, S_WAIT_CORE, S_WAIT_FIN: busy_o = 1'b1;
      S_DONE:  done_o = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    kk_d          = kk_q;
    nn_d          = nn_q;
    ll_d          = ll_q;
    first_d       = first_q;
    key_blk_d     = key_blk_q;
    cfg_err_d     = (state_q == S_IDLE) && cfg_v_i && !cfg_good;
    data_v_d      = emit;
    data_d        = take ? msg_i : 8'h00;
    data_idx_d    = emit ? idx : '0;
    block_first_d = emit && first_q;
    block_last_d  = emit && is_final;
    if (accept) begin
      kk_d      = kk_i;
      nn_d      = nn_i;
      ll_d      = ll_i;
      first_d   = 1'b1;
      key_blk_d = (kk_i != 8'd0);
    end else begin
      if (emit && idx_last) first_d = 1'b0;
      // Leaving the key block's stall: every later block is a message block.
      if ((state_q == S_WAIT_CORE) && core.core_block_done_i) key_blk_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kk_q          <= '0;
      nn_q          <= '0;
      ll_q          <= '0;
      first_q       <= 1'b0;
      key_blk_q     <= 1'b0;
      cfg_err_q     <= 1'b0;
      data_v_q      <= 1'b0;
      data_q        <= '0;
      data_idx_q    <= '0;
      block_first_q <= 1'b0;
      block_last_q  <= 1'b0;
    end else begin
      kk_q          <= kk_d;
      nn_q          <= nn_d;
      ll_q          <= ll_d;
      first_q       <= first_d;
      key_blk_q     <= key_blk_d;
      cfg_err_q     <= cfg_err_d;
      data_v_q      <= data_v_d;
      data_q        <= data_d;
      data_idx_q    <= data_idx_d;
      block_first_q <= block_first_d;
      block_last_q  <= block_last_d;
    end
  end

  assign cfg_err_o          = cfg_err_q;
  assign kk_o               = kk_q;
  assign nn_o               = nn_q;
  assign ll_o               = ll_q;
  assign core.data_v_o      = data_v_q;
  assign core.data_o        = data_q;
  assign core.data_idx_o    = data_idx_q;
  assign core.block_first_o = block_first_q;
  assign core.block_last_o  = block_last_q;

`ifdef BLAKE2S_SCHED_PERF_EN
  logic [31:0] cycles_q, cycles_d;

  // The accept cycle itself counts as the first cycle of the job.
  always_comb begin
    cycles_d = cycles_q;
    if (accept)                                     cycles_d = 32'd1;
    else if ((state_q != S_IDLE) && (cycles_q != '1)) cycles_d = cycles_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cycles_q <= '0;
    else       cycles_q <= cycles_d;
  end

  assign cycles_o = cycles_q;
`endif
endmodule

// File: tb/tb_blake2s_block_sched.sv
// tb/tb_blake2s_block_sched.sv - randomized bench for blake2s_block_sched against a block-level padding model
module tb_blake2s_block_sched;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, cfg_v_i, cfg_err_o, msg_v_i, msg_ready_o, busy_o, done_o;
  logic [7:0]  kk_i, nn_i, msg_i, kk_o, nn_o;
  logic [63:0] ll_i, ll_o;
`ifdef BLAKE2S_SCHED_PERF_EN
  logic [31:0] cycles_o;
`endif

  blake2s_block_sched_if #(.BLOCK_W(6)) core_if ();

  blake2s_block_sched #(.BLOCK_W(6), .LL_W(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_v_i     (cfg_v_i),
    .kk_i        (kk_i),
    .nn_i        (nn_i),
    .ll_i        (ll_i),
    .cfg_err_o   (cfg_err_o),
    .msg_v_i     (msg_v_i),
    .msg_i       (msg_i),
    .msg_ready_o (msg_ready_o),
    .kk_o        (kk_o),
    .nn_o        (nn_o),
    .ll_o        (ll_o),
    .core        (core_if),
    .busy_o      (busy_o),
    .done_o      (done_o)
`ifdef BLAKE2S_SCHED_PERF_EN
    ,
    .cycles_o    (cycles_o)
`endif
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  stim_q[$];
  logic [15:0] exp_q[$];  // {data, idx, first, last}

  // Key block (if any), then message zero-padded to whole blocks; empty job is one zero block.
  function automatic void build_expected(input int kk, input int ll);
    logic [7:0] blk[$];
    int nblk;
    exp_q.delete();
    if (kk > 0) for (int i = 0; i < 64; i++) blk.push_back(i < kk ? stim_q[i] : 8'h00);
    if (ll > 0) for (int i = 0; i < ((ll + 63) / 64) * 64; i++) blk.push_back(i < ll ? stim_q[kk + i] : 8'h00);
    if (kk == 0 && ll == 0) for (int i = 0; i < 64; i++) blk.push_back(8'h00);
    nblk = blk.size() / 64;
    for (int j = 0; j < blk.size(); j++)
      exp_q.push_back({blk[j], 6'(j % 64), 1'((j / 64) == 0), 1'((j / 64) == nblk - 1)});
  endfunction

  task automatic fill_random(input int n);
    stim_q.delete();
    repeat (n) stim_q.push_back(8'($urandom));
  endtask

  task automatic run_job(input int kk, input int nn, input int ll, input int vpct, input int dly,
                         input bit spur, input bit noise, input int stop_after);
    int ptr, blk_cnt, fin_cnt, job_cyc;
    bit will_accept, seen_done;
    logic [15:0] got, expv;
    build_expected(kk, ll);
    ptr = 0; blk_cnt = 0; fin_cnt = 0; job_cyc = 1; will_accept = 0; seen_done = 0;
    cfg_v_i = 1'b1; kk_i = 8'(kk); nn_i = 8'(nn); ll_i = 64'(ll);
    @(negedge clk);
    cfg_v_i = 1'b0;
    n_tests++;
    if ({busy_o, kk_o, nn_o, ll_o} !== {1'b1, 8'(kk), 8'(nn), 64'(ll)}) begin
      n_fail++;
      $display("FAIL accept busy/kk/nn/ll got %b/%0d/%0d/%0d want 1/%0d/%0d/%0d", busy_o, kk_o, nn_o, ll_o, kk, nn, ll);
    end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      job_cyc++;
      if (will_accept) ptr++;
      if (core_if.data_v_o) begin
        got = {core_if.data_o, core_if.data_idx_o, core_if.block_first_o, core_if.block_last_o};
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL extra_byte got %h want none", got);
        end else begin
          expv = exp_q.pop_front();
          if (got !== expv) begin
            n_fail++;
            $display("FAIL byte data/idx/first/last got %h/%0d/%b/%b want %h/%0d/%b/%b",
                     got[15:8], got[7:2], got[1], got[0], expv[15:8], expv[7:2], expv[1], expv[0]);
          end
        end
        if (core_if.data_idx_o == 6'd63) begin
          if (core_if.block_last_o) fin_cnt = dly + 1;
          else                      blk_cnt = dly + 1;
        end
      end
      if (ptr == stim_q.size()) begin
        n_tests++;
        if (msg_ready_o !== 1'b0) begin n_fail++; $display("FAIL ready_after_input got %b want 0", msg_ready_o); end
      end
      if (blk_cnt > 0) begin
        n_tests++;
        if (msg_ready_o !== 1'b0) begin n_fail++; $display("FAIL ready_in_stall got %b want 0", msg_ready_o); end
      end
      if (noise) begin
        n_tests++;
        if ({cfg_err_o, kk_o} !== {1'b0, 8'(kk)}) begin
          n_fail++;
          $display("FAIL busy_cfg err/kk got %b/%0d want 0/%0d", cfg_err_o, kk_o, kk);
        end
      end
      if (done_o) begin
        seen_done = 1;
        n_tests++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL done_busy got %b want 0", busy_o); end
        break;
      end
      if (stop_after >= 0 && ptr >= stop_after) return;
      core_if.core_block_done_i = 1'b0;
      core_if.core_finished_i   = 1'b0;
      if (blk_cnt > 0) begin
        blk_cnt--;
        if (blk_cnt == 0) core_if.core_block_done_i = 1'b1;
        else if (spur)    core_if.core_finished_i   = 1'b1;
      end
      if (fin_cnt > 0) begin
        fin_cnt--;
        if (fin_cnt == 0) core_if.core_finished_i   = 1'b1;
        else if (spur)    core_if.core_block_done_i = 1'b1;
      end
      msg_v_i = (ptr < stim_q.size()) && ($urandom_range(99) < vpct);
      msg_i   = msg_v_i ? stim_q[ptr] : 8'($urandom);
      if (noise) begin
        cfg_v_i = ($urandom_range(3) == 0);
        kk_i = 8'($urandom_range(40)); nn_i = 8'($urandom_range(40)); ll_i = 64'($urandom);
      end
      will_accept = msg_v_i && msg_ready_o;
      @(negedge clk);
    end
    cfg_v_i = 1'b0; msg_v_i = 1'b0;
    core_if.core_block_done_i = 1'b0; core_if.core_finished_i = 1'b0;
    n_tests++;
    if (!seen_done) begin n_fail++; $display("FAIL timeout done_o got 0 want 1"); end
    n_tests++;
    if (exp_q.size() != 0 || ptr != stim_q.size()) begin
      n_fail++;
      $display("FAIL leftover bytes_missing=%0d consumed=%0d want 0/%0d", exp_q.size(), ptr, stim_q.size());
    end
    @(negedge clk);
    n_tests++;
    if ({done_o, busy_o, msg_ready_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_after_done done/busy/ready got %b%b%b want 000", done_o, busy_o, msg_ready_o);
    end
`ifdef BLAKE2S_SCHED_PERF_EN
    n_tests++;
    if (cycles_o !== 32'(job_cyc)) begin n_fail++; $display("FAIL cycles got %0d want %0d", cycles_o, job_cyc); end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1; cfg_v_i = 1'b0; kk_i = '0; nn_i = '0; ll_i = '0; msg_v_i = 1'b0; msg_i = '0;
    core_if.core_block_done_i = 1'b0; core_if.core_finished_i = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({cfg_err_o, msg_ready_o, busy_o, done_o, kk_o, nn_o, ll_o, core_if.data_v_o, core_if.data_o,
         core_if.data_idx_o, core_if.block_first_o, core_if.block_last_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got busy=%b ready=%b dv=%b kk=%0d want all 0", busy_o, msg_ready_o, core_if.data_v_o, kk_o);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_empty();
    stim_q.delete();
    run_job(0, 32, 0, 100, 3, 1, 0, -1);
  endtask

  task automatic test_abc();
    stim_q.delete();
    stim_q.push_back(8'h61); stim_q.push_back(8'h62); stim_q.push_back(8'h63);
    run_job(0, 32, 3, 100, 0, 0, 0, -1);
  endtask

  task automatic test_key_msg();
    fill_random(96);
    run_job(32, 32, 64, 70, 5, 1, 0, -1);
  endtask

  task automatic test_stall();
    fill_random(65);
    run_job(0, 16, 65, 100, 10, 1, 0, -1);
  endtask

  task automatic test_cfg_err();
    logic [7:0] bad_kk[4] = '{8'd33, 8'd32, 8'd0, 8'd255};
    logic [7:0] bad_nn[4] = '{8'd32, 8'd0, 8'd33, 8'd5};
    for (int i = 0; i < 4; i++) begin
      cfg_v_i = 1'b1; kk_i = bad_kk[i]; nn_i = bad_nn[i]; ll_i = 64'd10;
      @(negedge clk);
      cfg_v_i = 1'b0;
      n_tests++;
      if ({cfg_err_o, busy_o} !== 2'b10) begin
        n_fail++;
        $display("FAIL cfg_err kk=%0d nn=%0d err/busy got %b%b want 10", bad_kk[i], bad_nn[i], cfg_err_o, busy_o);
      end
      @(negedge clk);
      n_tests++;
      if ({cfg_err_o, busy_o} !== 2'b00) begin
        n_fail++;
        $display("FAIL cfg_err_pulse kk=%0d err/busy got %b%b want 00", bad_kk[i], cfg_err_o, busy_o);
      end
    end
  endtask

  task automatic test_busy_cfg();
    fill_random(40);
    run_job(8, 20, 32, 60, 2, 0, 1, -1);
  endtask

  task automatic test_mid_reset();
    bit stray;
    fill_random(100);
    run_job(0, 32, 100, 100, 0, 0, 0, 20);
    reset = 1'b1; msg_v_i = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({cfg_err_o, msg_ready_o, busy_o, done_o, kk_o, nn_o, ll_o, core_if.data_v_o, core_if.data_o,
         core_if.data_idx_o, core_if.block_first_o, core_if.block_last_o} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs got busy=%b ready=%b dv=%b ll=%0d want all 0", busy_o, msg_ready_o, core_if.data_v_o, ll_o);
    end
    reset = 1'b0;
    stray = 0;
    repeat (20) begin
      @(negedge clk);
      stray |= done_o | busy_o;
    end
    n_tests++;
    if (stray !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle done|busy got %b want 0", stray); end
    fill_random(10);
    run_job(4, 8, 6, 80, 1, 0, 0, -1);
  endtask

  task automatic test_random();
    int kk, ll;
    for (int j = 0; j < 8; j++) begin
      kk = $urandom_range(32);
      case ($urandom_range(3))
        0:       ll = 0;
        1:       ll = 64 * $urandom_range(1, 3);
        default: ll = $urandom_range(1, 200);
      endcase
      fill_random(kk + ll);
      run_job(kk, $urandom_range(1, 32), ll, $urandom_range(30, 100), $urandom_range(6), 1'($urandom), 1'($urandom), -1);
    end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_abc();
    test_key_msg();
    test_stall();
    test_cfg_err();
    test_busy_cfg();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
